// File: rtl/kb_pkg.sv
// Shared scan-code constants and entry-state encoding for the
// PS/2 digit entry block.
package kb_pkg;

    localparam logic [8:0] KEY_0 = 9'h045;
    localparam logic [8:0] KEY_1 = 9'h016;
    localparam logic [8:0] KEY_2 = 9'h01E;
    localparam logic [8:0] KEY_3 = 9'h026;
    localparam logic [8:0] KEY_4 = 9'h025;
    localparam logic [8:0] KEY_5 = 9'h02E;
    localparam logic [8:0] KEY_6 = 9'h036;
    localparam logic [8:0] KEY_7 = 9'h03D;
    localparam logic [8:0] KEY_8 = 9'h03E;
    localparam logic [8:0] KEY_9 = 9'h046;

    localparam logic [8:0] KP_0 = 9'h070;
    localparam logic [8:0] KP_1 = 9'h069;
    localparam logic [8:0] KP_2 = 9'h072;
    localparam logic [8:0] KP_3 = 9'h07A;
    localparam logic [8:0] KP_4 = 9'h06B;
    localparam logic [8:0] KP_5 = 9'h073;
    localparam logic [8:0] KP_6 = 9'h074;
    localparam logic [8:0] KP_7 = 9'h06C;
    localparam logic [8:0] KP_8 = 9'h075;
    localparam logic [8:0] KP_9 = 9'h07D;

    localparam logic [8:0] KEY_BKSP  = 9'h066;
    localparam logic [8:0] KEY_ENTER = 9'h05A;
    localparam logic [8:0] KEY_ESC   = 9'h076;
    localparam logic [8:0] KP_ENTER  = 9'h15A;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/kb_scan2bcd.sv
// Scan code classifier: digit/BCD, backspace, enter, escape.
// Keypad digits and keypad Enter are accepted only with KB_KEYPAD_EN.
module kb_scan2bcd
    import kb_pkg::*;
(
    input  logic [8:0] i_code,
    output logic       o_is_digit,
    output logic [3:0] o_bcd,
    output logic       o_is_bksp,
    output logic       o_is_enter,
    output logic       o_is_esc
);

    always_comb begin
        o_is_digit = 1'b0;
        o_bcd      = 4'd0;
        o_is_bksp  = 1'b0;
        o_is_enter = 1'b0;
        o_is_esc   = 1'b0;
        case (i_code)
            KEY_0: begin o_is_digit = 1'b1; o_bcd = 4'd0; end
            KEY_1: begin o_is_digit = 1'b1; o_bcd = 4'd1; end
            KEY_2: begin o_is_digit = 1'b1; o_bcd = 4'd2; end
            KEY_3: begin o_is_digit = 1'b1; o_bcd = 4'd3; end
            KEY_4: begin o_is_digit = 1'b1; o_bcd = 4'd4; end
            KEY_5: begin o_is_digit = 1'b1; o_bcd = 4'd5; end
            KEY_6: begin o_is_digit = 1'b1; o_bcd = 4'd6; end
            KEY_7: begin o_is_digit = 1'b1; o_bcd = 4'd7; end
            KEY_8: begin o_is_digit = 1'b1; o_bcd = 4'd8; end
            KEY_9: begin o_is_digit = 1'b1; o_bcd = 4'd9; end
`ifdef KB_KEYPAD_EN
            KP_0: begin o_is_digit = 1'b1; o_bcd = 4'd0; end
            KP_1: begin o_is_digit = 1'b1; o_bcd = 4'd1; end
            KP_2: begin o_is_digit = 1'b1; o_bcd = 4'd2; end
            KP_3: begin o_is_digit = 1'b1; o_bcd = 4'd3; end
            KP_4: begin o_is_digit = 1'b1; o_bcd = 4'd4; end
            KP_5: begin o_is_digit = 1'b1; o_bcd = 4'd5; end
            KP_6: begin o_is_digit = 1'b1; o_bcd = 4'd6; end
            KP_7: begin o_is_digit = 1'b1; o_bcd = 4'd7; end
            KP_8: begin o_is_digit = 1'b1; o_bcd = 4'd8; end
            KP_9: begin o_is_digit = 1'b1; o_bcd = 4'd9; end
            KP_ENTER: o_is_enter = 1'b1;
`else
`endif
            KEY_BKSP:  o_is_bksp  = 1'b1;
            KEY_ENTER: o_is_enter = 1'b1;
            KEY_ESC:   o_is_esc   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/kb_digit_entry.sv
// Multi-digit BCD entry buffer driven by decoded PS/2 make events.
// Optional keypad support via KB_KEYPAD_EN (see kb_scan2bcd).
module kb_digit_entry
    import kb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               been_ready,
    input  logic [511:0]       key_down,
    input  logic [8:0]         last_change,
    output logic [4*DEPTH-1:0] digits,
    output logic [CNT_W-1:0]   count,
    output logic [3:0]         last_digit,
    output logic [4*DEPTH-1:0] commit_digits,
    output logic               commit_valid,
    output logic               full,
    output logic               overflow
);

    localparam int W = 4 * DEPTH;

    logic [511:0]     r_key_q;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_digits;
    logic [W-1:0]     w_digits_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [3:0]       r_last;
    logic [3:0]       w_last_nxt;
    logic [W-1:0]     r_cdig;
    logic [W-1:0]     w_cdig_nxt;
    logic             r_cvalid;
    logic             w_cvalid_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;

    logic             w_make;
    logic             w_act;
    logic             w_full;
    logic             w_digit;
    logic [3:0]       w_bcd;
    logic             w_bksp;
    logic             w_enter;
    logic             w_esc;

    kb_scan2bcd u_scan (
        .i_code     (last_change),
        .o_is_digit (w_digit),
        .o_bcd      (w_bcd),
        .o_is_bksp  (w_bksp),
        .o_is_enter (w_enter),
        .o_is_esc   (w_esc)
    );

    // Only the first make of a key counts; repeats see the bit already held.
    assign w_make = been_ready & key_down[last_change]
                  & ~r_key_q[last_change];
    assign w_act  = w_make & (r_state != COMMIT);
    assign w_full = (r_count == CNT_W'(DEPTH));

    always_comb begin
        w_state_nxt  = r_state;
        w_digits_nxt = r_digits;
        w_count_nxt  = r_count;
        w_last_nxt   = r_last;
        w_cdig_nxt   = r_cdig;
        w_cvalid_nxt = 1'b0;
        w_ovf_nxt    = r_ovf;
        if (r_state == COMMIT) begin
            w_state_nxt = IDLE;
        end
        if (w_act) begin
            unique case (1'b1)
                w_esc: begin
                    w_digits_nxt = '0;
                    w_count_nxt  = '0;
                    w_ovf_nxt    = 1'b0;
                    w_state_nxt  = IDLE;
                end
                w_digit: begin
                    if (w_full) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_digits_nxt = (r_digits << 4) | W'(w_bcd);
                        w_count_nxt  = r_count + CNT_W'(1);
                        w_last_nxt   = w_bcd;
                        w_state_nxt  = ENTRY;
                    end
                end
                w_bksp: begin
                    if (r_state == ENTRY) begin
                        w_digits_nxt = r_digits >> 4;
                        w_count_nxt  = r_count - CNT_W'(1);
                        if (r_count == CNT_W'(1)) begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
                w_enter: begin
                    if (r_state == ENTRY) begin
                        w_cdig_nxt   = r_digits;
                        w_cvalid_nxt = 1'b1;
                        w_digits_nxt = '0;
                        w_count_nxt  = '0;
                        w_ovf_nxt    = 1'b0;
                        w_state_nxt  = COMMIT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_q  <= '0;
            r_state  <= IDLE;
            r_digits <= '0;
            r_count  <= '0;
            r_last   <= '0;
            r_cdig   <= '0;
            r_cvalid <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_key_q  <= key_down;
            r_state  <= w_state_nxt;
            r_digits <= w_digits_nxt;
            r_count  <= w_count_nxt;
            r_last   <= w_last_nxt;
            r_cdig   <= w_cdig_nxt;
            r_cvalid <= w_cvalid_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    assign digits        = r_digits;
    assign count         = r_count;
    assign last_digit    = r_last;
    assign commit_digits = r_cdig;
    assign commit_valid  = r_cvalid;
    assign full          = w_full;
    assign overflow      = r_ovf;

endmodule

// File: tb/tb_kb_digit_entry.sv
// Directed bench for kb_digit_entry with a commit scoreboard.
// Build with +define+KB_KEYPAD_EN to cover the keypad path.
module tb_kb_digit_entry;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               clk;
    logic               rst;
    logic               been_ready;
    logic [511:0]       key_down;
    logic [8:0]         last_change;
    logic [4*DEPTH-1:0] digits;
    logic [CNT_W-1:0]   count;
    logic [3:0]         last_digit;
    logic [4*DEPTH-1:0] commit_digits;
    logic               commit_valid;
    logic               full;
    logic               overflow;

    int n_pass  = 0;
    int n_total = 0;
    int n_seen  = 0;
    logic [4*DEPTH-1:0] sb_q[$];

    kb_digit_entry #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .been_ready    (been_ready),
        .key_down      (key_down),
        .last_change   (last_change),
        .digits        (digits),
        .count         (count),
        .last_digit    (last_digit),
        .commit_digits (commit_digits),
        .commit_valid  (commit_valid),
        .full          (full),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One decoded PS/2 event held for a single cycle.
    task automatic ev(input logic [8:0] code, input logic down);
        @(negedge clk);
        been_ready       = 1'b1;
        last_change      = code;
        key_down[code]   = down;
        @(negedge clk);
        been_ready       = 1'b0;
    endtask

    task automatic press(input logic [8:0] code);
        ev(code, 1'b1);
        ev(code, 1'b0);
    endtask

    // Scoreboard: every pulse must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (rst && commit_valid) begin
            n_seen++;
            if (sb_q.size() == 0) begin
                chk("spurious_commit", 32'(commit_valid), 32'd0);
            end else begin
                chk("commit_digits", 32'(commit_digits),
                    32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        rst         = 1'b0;
        been_ready  = 1'b0;
        key_down    = '0;
        last_change = '0;
        repeat (3) @(negedge clk);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_cvalid", 32'(commit_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        rst = 1'b1;

        press(9'h016);
        press(9'h01E);
        press(9'h026);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_digits", 32'(digits[11:0]), 32'h123);
        chk("t1_last", 32'(last_digit), 32'd3);
        press(9'h116);
        press(9'h01C);
        chk("ignored_count", 32'(count), 32'd3);
        press(9'h076);
        chk("esc_count", 32'(count), 32'd0);
        chk("esc_digits", 32'(digits), 32'h0);

        ev(9'h03D, 1'b1);
        ev(9'h03D, 1'b1);
        ev(9'h03D, 1'b1);
        ev(9'h03D, 1'b0);
        chk("rpt_count", 32'(count), 32'd1);
        chk("rpt_digit", 32'(digits[3:0]), 32'd7);
        press(9'h076);

        press(9'h02E);
        press(9'h036);
        press(9'h03D);
        press(9'h03E);
        chk("full_at4", 32'(full), 32'd1);
        chk("no_ovf_yet", 32'(overflow), 32'd0);
        press(9'h046);
        chk("ovf_digits", 32'(digits), 32'h5678);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_last", 32'(last_digit), 32'd8);
        press(9'h066);
        chk("bk_digits", 32'(digits), 32'h0567);
        chk("bk_count", 32'(count), 32'd3);
        chk("bk_full", 32'(full), 32'd0);
        chk("bk_ovf", 32'(overflow), 32'd1);
        press(9'h076);
        chk("esc_ovf", 32'(overflow), 32'd0);

        press(9'h025);
        press(9'h01E);
        sb_q.push_back(16'h0042);
        ev(9'h05A, 1'b1);
        chk("cm_valid", 32'(commit_valid), 32'd1);
        chk("cm_count", 32'(count), 32'd0);
        ev(9'h05A, 1'b0);
        chk("cm_pulse1", 32'(commit_valid), 32'd0);
        ev(9'h05A, 1'b1);
        chk("idle_enter", 32'(commit_valid), 32'd0);
        ev(9'h05A, 1'b0);

        press(9'h066);
        chk("idle_bksp", 32'(count), 32'd0);

        press(9'h069);
`ifdef KB_KEYPAD_EN
        chk("kp_count", 32'(count), 32'd1);
        chk("kp_digit", 32'(digits[3:0]), 32'd1);
`else
        chk("kp_count", 32'(count), 32'd0);
`endif
        press(9'h076);

        press(9'h046);
        press(9'h046);
        chk("pre_rst", 32'(digits[7:0]), 32'h99);
        #2 rst = 1'b0;
        #1;
        chk("arst_digits", 32'(digits), 32'h0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_last", 32'(last_digit), 32'd0);
        chk("arst_cdig", 32'(commit_digits), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        ev(9'h05A, 1'b1);
        chk("post_rst_enter", 32'(commit_valid), 32'd0);
        ev(9'h05A, 1'b0);
        chk("post_rst_count", 32'(count), 32'd0);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("commits_seen", 32'(n_seen), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
